// File: rtl/move_btn_conditioner_pkg.sv
// move_btn_conditioner_pkg: shared button indices, channel states and idle move code.
package move_btn_conditioner_pkg;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_RIGHT = 3;
  localparam logic [3:0] MOVE_NONE = 4'b1111;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } chan_state_t;
endpackage

// File: rtl/move_btn_conditioner_btn_channel.sv
// btn_channel: sync, debounce, press-edge strobe and auto-repeat for one active-low button.
// AUTO_REPEAT_EN selects DELAY/REPEAT auto-repeat; otherwise a single HELD state gives one strobe per press.
module btn_channel
  import move_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic strobe_n,
  output logic held
);
  logic s1, s2, clean;
  logic [CNT_W-1:0] dcnt;
  chan_state_t state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      clean <= 1'b1;
      held  <= 1'b0;
      dcnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) dcnt <= '0;
      else if (dcnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean <= s2;
        held  <= ~s2;
        dcnt  <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  end
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] rcnt;
  // Release is tested before the terminal count so it always wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rcnt     <= '0;
      strobe_n <= 1'b1;
    end else begin
      strobe_n <= 1'b1;
      case (state)
        IDLE: if (!clean) begin
          strobe_n <= 1'b0;
          rcnt     <= '0;
          state    <= DELAY;
        end
        DELAY: if (clean) begin
          rcnt  <= '0;
          state <= IDLE;
        end else if (rcnt == CNT_W'(REPEAT_DELAY - 1)) begin
          strobe_n <= 1'b0;
          rcnt     <= '0;
          state    <= REPEAT;
        end else rcnt <= rcnt + 1'b1;
        REPEAT: if (clean) begin
          rcnt  <= '0;
          state <= IDLE;
        end else if (rcnt == CNT_W'(REPEAT_PERIOD - 1)) begin
          strobe_n <= 1'b0;
          rcnt     <= '0;
        end else rcnt <= rcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      strobe_n <= 1'b1;
    end else begin
      strobe_n <= 1'b1;
      case (state)
        IDLE: if (!clean) begin
          strobe_n <= 1'b0;
          state    <= HELD;
        end
        HELD: if (clean) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: rtl/move_btn_conditioner.sv
// move_btn_conditioner: four independent button channels producing active-low move strobes.
// Auto-repeat is enabled by defining AUTO_REPEAT_EN.
module move_btn_conditioner
  import move_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] move,
  output logic [3:0] held
);
  for (genvar i = BTN_LEFT; i <= BTN_RIGHT; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw     (btn_raw[i]),
      .strobe_n(move[i]),
      .held    (held[i])
    );
  end
endmodule

// File: tb/tb_move_btn_conditioner.sv
// tb_move_btn_conditioner: directed checks of press, repeat, bounce, collision and reset behaviour.
module tb_move_btn_conditioner;
  import move_btn_conditioner_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn_raw = 4'hF;
  logic [3:0] move, held;
  int checks = 0;
  int failures = 0;
  move_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (25)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .move   (move),
    .held   (held)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // Strobe cycles counted from the press drive: press at 7, repeats at 17, 20, 23, ...
  function automatic bit rep(input int k);
`ifdef AUTO_REPEAT_EN
    return k == 7 || (k >= 17 && (k - 17) % 3 == 0);
`else
    return k == 7;
`endif
  endfunction
  // Press buttons in m before cycle 1, release at cycle r; clean rises at cycle r+5.
  task automatic phase(input string tag, input logic [3:0] m, input int n, input int r);
    btn_raw = ~m;
    for (int k = 1; k <= n; k++) begin
      if (k == r) btn_raw = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_move_%0d", tag, k), move, (rep(k) && k <= r + 5) ? ~m : MOVE_NONE);
      chk($sformatf("%s_held_%0d", tag, k), held, (k >= 6 && k < r + 5) ? m : 4'h0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_move", move, MOVE_NONE);
    chk("reset_held", held, 4'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    phase("left", 4'b0001, 30, 21);
    phase("collide", 4'b0010, 35, 23);
    for (int k = 1; k <= 32; k++) begin
      btn_raw = {((k - 1) / 2) % 2 == 1, 3'b111};
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bounce_move_%0d", k), move, MOVE_NONE);
      chk($sformatf("bounce_held_%0d", k), held, 4'h0);
    end
    phase("bounce_press", 4'b1000, 16, 9);
    phase("simul", 4'b0110, 16, 9);
    phase("rst_a", 4'b0100, 20, 1000);
    rst = 1'b1;
    #1;
    chk("rst_async_move", move, MOVE_NONE);
    chk("rst_async_held", held, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    phase("rst_b", 4'b0100, 16, 9);
    phase("hold", 4'b0001, 56, 51);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/move_btn_conditioner.md
Name: move_btn_conditioner

Overview:
- Upstream stage of the cursor mover.
- Converts four raw, asynchronous, active-low push-buttons into clean move[3:0] strobes.
  - Strobes are one cycle wide and active-low.
  - Index order: 0=left, 1=down, 2=up, 3=right.
- Per button: synchronise, debounce, detect the press edge, then auto-repeat while the button is held.
- Output drives the cursor mover's move input directly; released = 4'b1111.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the clean level changes (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the press strobe to the first repeat strobe.
- REPEAT_PERIOD, 5000000, cycles between successive repeat strobes.
- CNT_W, 25, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  4  raw buttons, active-low, asynchronous to clk.
- move  output  4  registered strobes, active-low, one cycle per event.
- held  output  4  registered debounced level, active-high (1 = button pressed).

Behaviour:
- Reset (asynchronous, active-high; takes effect mid-operation too):
  - Sync flops = 1.
  - Clean levels = 1 (released), so held = 0.
  - All counters = 0, all channels IDLE, move = 4'b1111.
- Synchroniser: two flops per bit; the debouncer sees only the second stage.
- Debounce (per bit):
  - While sync differs from clean, a counter increments each cycle.
  - When the count reaches DEBOUNCE_CYCLES-1 with sync still differing, clean <= sync and the counter clears.
  - Any cycle where sync equals clean clears the counter, so a bounce restarts the count.
- Latency from raw edge to clean change: 2 + DEBOUNCE_CYCLES cycles.
- Per-channel FSM (IDLE, DELAY, REPEAT):
  - IDLE: clean falling (1->0) => move[i]=0 for exactly the next cycle; go to DELAY; repeat counter = 0.
  - DELAY: counter increments. At REPEAT_DELAY-1, emit a strobe, clear the counter, go to REPEAT.
  - REPEAT: counter increments. At REPEAT_PERIOD-1, emit a strobe and clear the counter; stay in REPEAT.
  - DELAY or REPEAT with clean rising => IDLE, counter cleared, no strobe on release.
  - A release in the same cycle a terminal count would fire: release wins, no strobe.
- Strobe rule: move[i] is low for exactly one cycle per event, never two consecutive cycles.
  - Requires REPEAT_PERIOD >= 2; REPEAT_PERIOD < 2 is illegal.
- Channels are fully independent.
  - Simultaneous presses give simultaneous strobes.
  - Opposite directions (0&3, 1&2) both pass; the consumer resolves them.
- held[i] = ~clean[i], registered, with the same timing as the clean level.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: full IDLE/DELAY/REPEAT behaviour as above.
- Undefined:
  - DELAY and REPEAT collapse into one HELD state with no counter.
  - Exactly one strobe per press; nothing further until release and a new debounced press.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Shared package/include holds:
  - Button index constants BTN_LEFT=0, BTN_DOWN=1, BTN_UP=2, BTN_RIGHT=3, reused by the cursor mover.
  - Channel state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
  - MOVE_NONE = 4'b1111.
- Sub-module btn_channel: one button's synchroniser, debounce counter, FSM and repeat counter; instantiated 4 times by generate.
- Top level does only instantiation and bit concatenation.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, AUTO_REPEAT_EN defined unless stated):
- Clean press/release:
  - Drive btn_raw[0]=0 at cycle 0 and hold 20 cycles -> move[0] low exactly at cycle 7 (2 sync + 4 debounce + 1).
  - Then low at cycles 17, 20; held[0]=1 from cycle 6.
  - Release -> no strobe; held[0]=0 after 6 cycles.
- Bounce rejection:
  - Toggle btn_raw[3] every 2 cycles for 30 cycles -> move stays 4'b1111 and held stays 0.
  - Then hold it low -> a single strobe 7 cycles after the last edge.
- Simultaneous buttons: btn_raw=4'b1001 at the same cycle -> move=4'b1001 for one cycle at cycle 7; all other cycles 4'b1111.
- Release vs repeat collision: hold btn_raw[1] low until its clean release coincides with the REPEAT terminal count -> no strobe that cycle; channel returns to IDLE.
- Reset mid-operation:
  - Assert rst for 1 cycle while btn_raw[2] is held in REPEAT -> move=4'b1111 and held=0 immediately (asynchronous).
  - After deassertion with the button still low -> a new press strobe after 7 cycles.
- AUTO_REPEAT_EN undefined: hold btn_raw[0] low for 50 cycles -> exactly one strobe at cycle 7.
